// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared types and default widths for the hazard controller.
// Rev    : 1.0
// ============================================================================
package hazard_pkg;

    localparam int c_reg_aw_default = 5;
    localparam int c_lat_w_default  = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_mc_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; synchronous clear wins.
// Rev    : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl_mc
// Brief  : 5-stage hazard controller with multi-cycle EX hold and perf counters.
// Rev    : 1.0
// ============================================================================
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = c_reg_aw_default,
    parameter int LAT_W  = c_lat_w_default,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcE_zero,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              McStartE,
    input  logic [LAT_W-1:0]  McLatE,
    input  logic              PerfClr,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy,
    output logic [PERF_W-1:0] LwStallCnt,
    output logic [PERF_W-1:0] McStallCnt,
    output logic [PERF_W-1:0] FlushCnt
);

    localparam logic [1:0] c_st_idle = MC_IDLE;
    localparam logic [1:0] c_st_busy = MC_BUSY;
    localparam logic [1:0] c_st_done = MC_DONE;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_cnt_next;
    logic             w_mc_stall;
    logic             w_lw_stall;

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
            return FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign w_lw_stall = ResultSrcE_zero && (RdE != '0) &&
                        ((Rs1D == RdE) || (Rs2D == RdE));

    // cnt is loaded with L-3 so BUSY lasts L-2 cycles after the IDLE stall.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_mc_stall   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (McStartE && (McLatE >= LAT_W'(2))) begin
                    w_mc_stall   = 1'b1;
                    w_cnt_next   = McLatE - LAT_W'(3);
                    w_next_state = (McLatE == LAT_W'(2)) ? c_st_done : c_st_busy;
                end
            end
            c_st_busy: begin
                w_mc_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = c_st_done;
                end else begin
                    w_cnt_next = r_cnt - LAT_W'(1);
                end
            end
            c_st_done: begin
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    assign McBusy = (r_state == c_st_busy);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (w_mc_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end
    end

    sat_counter #(.W(PERF_W)) u_lw_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (w_lw_stall),
        .clr   (PerfClr),
        .count (LwStallCnt)
    );

    sat_counter #(.W(PERF_W)) u_mc_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (w_mc_stall),
        .clr   (PerfClr),
        .count (McStallCnt)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (FlushD || FlushE),
        .clr   (PerfClr),
        .count (FlushCnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl_mc
// Brief  : Scoreboard bench for hazard_ctrl_mc (PERF_W=4 for saturation).
// Rev    : 1.0
// ============================================================================
module tb_hazard_ctrl_mc;

    localparam int REG_AW = 5;
    localparam int LAT_W  = 4;
    localparam int PERF_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, McStartE, PerfClr;
    logic [LAT_W-1:0]  McLatE;
    logic              StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [PERF_W-1:0] LwStallCnt, McStallCnt, FlushCnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_AW(REG_AW), .LAT_W(LAT_W), .PERF_W(PERF_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .Rs1D            (Rs1D),
        .Rs2D            (Rs2D),
        .Rs1E            (Rs1E),
        .Rs2E            (Rs2E),
        .RdE             (RdE),
        .ResultSrcE_zero (ResultSrcE_zero),
        .RdM             (RdM),
        .RegWriteM       (RegWriteM),
        .RdW             (RdW),
        .RegWriteW       (RegWriteW),
        .PCSrcE          (PCSrcE),
        .McStartE        (McStartE),
        .McLatE          (McLatE),
        .PerfClr         (PerfClr),
        .StallF          (StallF),
        .StallD          (StallD),
        .StallE          (StallE),
        .FlushD          (FlushD),
        .FlushE          (FlushE),
        .FlushM          (FlushM),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .McBusy          (McBusy),
        .LwStallCnt      (LwStallCnt),
        .McStallCnt      (McStallCnt),
        .FlushCnt        (FlushCnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM,ForwardAE,ForwardBE,McBusy}
    function automatic logic [10:0] ev(input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic busy);
        return {sf, sd, se, fd, fe, fm, fa, fb, busy};
    endfunction

    localparam logic [10:0] c_zero  = 11'b0;
    localparam logic [10:0] c_mc    = 11'b111_001_00_00_0;
    localparam logic [10:0] c_mc_bz = 11'b111_001_00_00_1;
    localparam logic [10:0] c_lw    = 11'b110_010_00_00_0;
    localparam logic [10:0] c_br    = 11'b000_110_00_00_0;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            check_val(it.tag,
                      {21'b0, StallF, StallD, StallE, FlushD, FlushE, FlushM,
                       ForwardAE, ForwardBE, McBusy},
                      {21'b0, it.exp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [10:0] e);
        sb_item_t it;
        it.tag = tag;
        it.exp = e;
        sb_q.push_back(it);
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, McStartE, PerfClr} = '0;
        McLatE = '0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        expect_out("reset_outputs", c_zero);
        #2;
        check_val("reset_lwcnt", 32'(LwStallCnt), 32'd0);
        check_val("reset_mccnt", 32'(McStallCnt), 32'd0);
        check_val("reset_flcnt", 32'(FlushCnt), 32'd0);
        tick();
        reset = 1'b0;

        // Forwarding
        tick();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 0;
        expect_out("fwd_mem_pri", ev(0,0,0,0,0,0,2'b10,2'b00,0));
        tick();
        RegWriteM = 0; Rs2E = 5;
        expect_out("fwd_wb", ev(0,0,0,0,0,0,2'b01,2'b01,0));
        tick();
        RegWriteM = 1; RdM = 3; Rs2E = 3;
        expect_out("fwd_b_mem", ev(0,0,0,0,0,0,2'b01,2'b10,0));
        tick();
        RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
        expect_out("fwd_x0", c_zero);

        // Load-use
        tick();
        clear_inputs();
        ResultSrcE_zero = 1; RdE = 7; Rs2D = 7;
        expect_out("lw_stall", c_lw);
        tick();
        clear_inputs();
        expect_out("lw_after", c_zero);
        #2 check_val("lw_cnt1", 32'(LwStallCnt), 32'd1);
        tick();
        ResultSrcE_zero = 1; RdE = 0; Rs1D = 0; Rs2D = 0;
        expect_out("lw_rd0", c_zero);

        // Multi-cycle latency 4 with McStartE held
        do_reset();
        tick(); McStartE = 1; McLatE = 4; expect_out("mc4_c1", c_mc);
        tick(); expect_out("mc4_c2", c_mc_bz);
        tick(); expect_out("mc4_c3", c_mc_bz);
        tick(); expect_out("mc4_done", c_zero);
        tick(); McStartE = 0; expect_out("mc4_idle", c_zero);
        #2 check_val("mc4_cnt", 32'(McStallCnt), 32'd3);
        tick(); McStartE = 1; McLatE = 1; expect_out("mc1_nostall", c_zero);
        tick(); McLatE = 0; expect_out("mc0_nostall", c_zero);
        // Latency 2 back-to-back: accepted again in the IDLE after DONE
        tick(); McLatE = 2; expect_out("mc2_a_stall", c_mc);
        tick(); expect_out("mc2_a_done", c_zero);
        tick(); expect_out("mc2_b_stall", c_mc);
        tick(); expect_out("mc2_b_done", c_zero);
        tick(); McStartE = 0; expect_out("mc2_idle", c_zero);
        #2 check_val("mc2_cnt", 32'(McStallCnt), 32'd5);

        // Priority: multi-cycle over load-use over branch
        do_reset();
        tick();
        McStartE = 1; McLatE = 3; PCSrcE = 1; ResultSrcE_zero = 1; RdE = 7; Rs1D = 7;
        expect_out("pri_c1", c_mc);
        tick(); expect_out("pri_c2", c_mc_bz);
        tick(); ResultSrcE_zero = 0; RdE = 0; Rs1D = 0;
        expect_out("pri_done_br", c_br);
        tick(); McStartE = 0; PCSrcE = 0; expect_out("pri_idle", c_zero);
        #2;
        check_val("pri_flcnt", 32'(FlushCnt), 32'd1);
        check_val("pri_lwcnt", 32'(LwStallCnt), 32'd2);
        check_val("pri_mccnt", 32'(McStallCnt), 32'd2);

        // Reset during BUSY
        tick(); McStartE = 1; McLatE = 8; expect_out("rst_c1", c_mc);
        tick(); expect_out("rst_c2", c_mc_bz);
        tick(); reset = 1; clear_inputs(); expect_out("rst_mid", c_zero);
        #2 check_val("rst_mccnt", 32'(McStallCnt), 32'd0);
        tick(); reset = 0; expect_out("rst_release", c_zero);
        tick(); McStartE = 1; McLatE = 2; expect_out("rst_new_op", c_mc);
        tick(); McStartE = 0; expect_out("rst_new_done", c_zero);

        // Saturation of a 4-bit counter, then clear beating increment
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            ResultSrcE_zero = 1; RdE = 9; Rs1D = 9;
            expect_out("sat_lw", c_lw);
        end
        tick(); PerfClr = 1; expect_out("sat_clr_cycle", c_lw);
        #2 check_val("sat_held", 32'(LwStallCnt), 32'd15);
        tick(); PerfClr = 0; clear_inputs(); expect_out("sat_after", c_zero);
        #2 check_val("sat_cleared", 32'(LwStallCnt), 32'd0);

        begin
            int wait_cyc = 0;
            while (sb_q.size() > 0 && wait_cyc < 10) begin
                @(posedge clk);
                wait_cyc++;
            end
            if (sb_q.size() > 0) begin
                check_val("scoreboard_drain", 32'(sb_q.size()), 32'd0);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised pipeline hazard controller for the 5-stage core, extended for a variable-latency execute unit (mul/div).
- Drives stall, flush and forwarding selects into the datapath.
- Adds multi-cycle EX holding, MEM bubble insertion and saturating performance counters.
- Sits beside the datapath and consumes the register IDs and control bits exported by each stage.

Parameters:
- REG_AW, 5, register-index width; register 0 is hard-wired zero.
- LAT_W, 4, width of the multi-cycle latency input; maximum latency is 2^LAT_W-1.
- PERF_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  REG_AW  source registers in ID
- Rs1E, Rs2E, RdE  in  REG_AW  sources and destination in EX
- ResultSrcE_zero  in  1  EX instruction is a load
- RdM  in  REG_AW  MEM destination
- RegWriteM  in  1  MEM writes the register file
- RdW  in  REG_AW  WB destination
- RegWriteW  in  1  WB writes the register file
- PCSrcE  in  1  taken branch/jump in EX
- McStartE  in  1  EX holds a multi-cycle op
- McLatE  in  LAT_W  latency of that op in cycles
- PerfClr  in  1  synchronous clear of the performance counters
- StallF, StallD, StallE  out  1  hold PC, IF/ID and ID/EX
- FlushD, FlushE, FlushM  out  1  bubble into ID, EX, MEM
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 WB, 10 MEM
- McBusy  out  1  registered; high in state BUSY
- LwStallCnt, McStallCnt, FlushCnt  out  PERF_W  performance counters

Behaviour:
- Forwarding (combinational), shown for A; B is identical using Rs2E:
  - 10 if RegWriteM and RdM!=0 and RdM==Rs1E;
  - else 01 if RegWriteW and RdW!=0 and RdW==Rs1E;
  - else 00.
  - MEM has priority over WB.
- Load-use stall: lwStall = ResultSrcE_zero and RdE!=0 and (Rs1D==RdE or Rs2D==RdE).
- Multi-cycle FSM states: IDLE, BUSY, DONE; down-counter cnt of width LAT_W.
  - IDLE: if McStartE and McLatE>=2, mcStall=1 this cycle and cnt<=McLatE-3. Next state is DONE when McLatE==2, otherwise BUSY.
  - IDLE: McLatE of 0 or 1 means no stall and the state stays IDLE.
  - BUSY: mcStall=1; if cnt==0 go to DONE, else decrement cnt.
  - DONE: mcStall=0, McStartE ignored (the same op is leaving EX), next state IDLE.
  - Result: an op of latency L stalls exactly L-1 cycles and advances in cycle L.
- Output priority: mcStall > lwStall > branch.
  - mcStall: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0. PCSrcE is ignored, since multi-cycle ops never branch.
  - else lwStall: StallF=StallD=1, FlushE=1.
  - else PCSrcE: FlushD=FlushE=1.
  - Default: all stall and flush outputs are 0.
- Back-to-back multi-cycle ops: the second op is accepted in the IDLE cycle after DONE.
- Performance counters:
  - Each cycle, LwStallCnt increments on lwStall (unmasked), McStallCnt on mcStall, and FlushCnt on FlushD or FlushE.
  - All three saturate at all-ones; they never wrap.
  - PerfClr has priority over increment and forces 0 on the next edge.
- Reset, including mid-operation: state=IDLE, cnt=0, McBusy=0, counters=0, all asynchronous.
  - With all inputs 0, every output is 0.
  - A BUSY op aborted by reset releases its stalls immediately.

Decomposition:
- hazard_pkg contains:
  - enum fwd_sel_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10};
  - enum mc_state_e {MC_IDLE, MC_BUSY, MC_DONE};
  - default localparams for REG_AW and LAT_W.
- One sub-module, sat_counter #(W): inc, clr, async reset, saturating output. It is instantiated three times.

Test Plan:
- Forwarding: RdM=5/RegWriteM=1 and RdW=5/RegWriteW=1, Rs1E=5 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=0 with Rs1E=0 -> 00.
- Load-use: ResultSrcE_zero=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; LwStallCnt=1. Repeat with RdE=0 -> no stall.
- Multi-cycle with McLatE=4, McStartE held -> StallE/FlushM high for exactly 3 cycles, McBusy high for 2 cycles, DONE on cycle 4, McStallCnt=3. Repeat with McLatE=1 -> no stall; McLatE=2 -> exactly 1 stall cycle.
- Priority: McStartE=1, McLatE=3 together with PCSrcE=1 and lwStall conditions -> only the multi-cycle stall pattern. After DONE, PCSrcE=1 -> FlushD=FlushE=1, FlushCnt increments.
- Reset mid-BUSY (McLatE=8, reset asserted in cycle 3) -> all outputs 0 before the next edge; state IDLE on release.
- Saturation with PERF_W=4: 20 lwStall cycles -> LwStallCnt=15 and held. Then PerfClr=1 together with lwStall -> 0.
